// File: rtl/time_set_controller_if.sv
// Button/timebase inputs and counter/display outputs of the time-set controller.
// master drives the buttons and tick; slave is the controller itself.
interface time_set_controller_if;
  logic       ModePulse;
  logic       IncPulse;
  logic       IncLevel;
  logic       Tick;
  logic       RunEn;
  logic       IncHr;
  logic       IncMin;
  logic       IncSec;
  logic [1:0] Field;
  logic       Blink;

  modport master (
    output ModePulse, IncPulse, IncLevel, Tick,
    input  RunEn, IncHr, IncMin, IncSec, Field, Blink
  );

  modport slave (
    input  ModePulse, IncPulse, IncLevel, Tick,
    output RunEn, IncHr, IncMin, IncSec, Field, Blink
  );
endinterface

// File: rtl/time_set_controller.sv
// Run/edit sequencer for the clock datapath: field select, increment strobes, auto-repeat, edit timeout.
// Every output is a flop, one cycle after its cause; no backpressure, all inputs are single-cycle pulses or levels.
module time_set_controller #(
  parameter int CNT_W        = 16,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int TIMEOUT      = 1000
) (
  input  logic                 Clk,
  input  logic                 Rst,
  time_set_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_SET_HR  = 2'd1,
    S_SET_MIN = 2'd2,
    S_SET_SEC = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DELAY_C   = CNT_W'(REPEAT_DELAY);
  // After each repeat strobe the counter steps back one period, so it never climbs past DELAY_C.
  localparam logic [CNT_W-1:0] RELOAD_C  = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             armed_q, armed_d;
  logic             run_en_q, run_en_d;
  logic             blink_q, blink_d;
  logic             inc_hr_q, inc_hr_d;
  logic             inc_min_q, inc_min_d;
  logic             inc_sec_q, inc_sec_d;

  logic             edit;
  logic             activity;
  logic             timeout;
  logic             strobe;
  logic [CNT_W-1:0] rpt_inc;
  logic [CNT_W-1:0] idle_inc;

  always_comb begin
    state_d   = state_q;
    rpt_d     = rpt_q;
    idle_d    = idle_q;
    armed_d   = armed_q;
    blink_d   = blink_q;
    run_en_d  = 1'b1;
    inc_hr_d  = 1'b0;
    inc_min_d = 1'b0;
    inc_sec_d = 1'b0;
    timeout   = 1'b0;
    strobe    = 1'b0;
    edit      = (state_q != S_RUN);
    activity  = bus.ModePulse | bus.IncPulse | bus.IncLevel;
    rpt_inc   = rpt_q + 1'b1;
    idle_inc  = idle_q + 1'b1;

    if (!edit || activity) begin
      idle_d = '0;
    end else if (idle_inc >= TIMEOUT_C) begin
      timeout = 1'b1;
      idle_d  = '0;
    end else begin
      idle_d = idle_inc;
    end

    if (bus.ModePulse) begin
      case (state_q)
        S_RUN:     state_d = S_SET_HR;
        S_SET_HR:  state_d = S_SET_MIN;
        S_SET_MIN: state_d = S_SET_SEC;
        default:   state_d = S_RUN;
      endcase
    end else if (timeout) begin
      state_d = S_RUN;
    end

    // Repeat is armed only by an accepted press; a mode change or released level disarms it.
    if (!edit || bus.ModePulse) begin
      armed_d = 1'b0;
      rpt_d   = '0;
    end else if (bus.IncPulse) begin
      armed_d = 1'b1;
      rpt_d   = '0;
      strobe  = 1'b1;
    end else if (armed_q && bus.IncLevel) begin
      if (rpt_inc == DELAY_C) begin
        strobe = 1'b1;
        rpt_d  = RELOAD_C;
      end else begin
        rpt_d = rpt_inc;
      end
    end else begin
      armed_d = 1'b0;
      rpt_d   = '0;
    end

    inc_hr_d  = strobe && (state_q == S_SET_HR);
    inc_min_d = strobe && (state_q == S_SET_MIN);
    inc_sec_d = (strobe && (state_q == S_SET_SEC)) || (!edit && bus.Tick);
    run_en_d  = (state_d == S_RUN);

    if (state_d == S_RUN || state_d != state_q) begin
      blink_d = 1'b1;
    end else if (bus.Tick) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= S_RUN;
      rpt_q     <= '0;
      idle_q    <= '0;
      armed_q   <= 1'b0;
      run_en_q  <= 1'b1;
      blink_q   <= 1'b1;
      inc_hr_q  <= 1'b0;
      inc_min_q <= 1'b0;
      inc_sec_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_q     <= rpt_d;
      idle_q    <= idle_d;
      armed_q   <= armed_d;
      run_en_q  <= run_en_d;
      blink_q   <= blink_d;
      inc_hr_q  <= inc_hr_d;
      inc_min_q <= inc_min_d;
      inc_sec_q <= inc_sec_d;
    end
  end

  assign bus.RunEn  = run_en_q;
  assign bus.IncHr  = inc_hr_q;
  assign bus.IncMin = inc_min_q;
  assign bus.IncSec = inc_sec_q;
  assign bus.Field  = state_q;
  assign bus.Blink  = blink_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed steps plus random traffic against a behavioural model.
module tb_time_set_controller;
  localparam int DLY  = 50;
  localparam int RATE = 10;
  localparam int TMO  = 1000;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n_hr, n_min, n_sec;
  bit   lvl;

  // behavioural model state
  int m_field, m_n, m_idle;
  bit m_blink, m_armed, e_hr, e_min, e_sec;

  time_set_controller_if bus ();

  time_set_controller #(
    .CNT_W(16), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .TIMEOUT(TMO)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_field = 0; m_n = 0; m_idle = 0;
    m_blink = 1'b1; m_armed = 1'b0;
    e_hr = 1'b0; e_min = 1'b0; e_sec = 1'b0;
  endfunction

  // One clock of the rules: inputs of this cycle -> expected outputs of the next.
  function automatic void model(input bit mp, input bit ip, input bit il, input bit tk);
    bit edit, to, str;
    int nxt;
    edit = (m_field != 0);
    nxt  = m_field;
    to   = 1'b0;
    str  = 1'b0;
    e_hr = 1'b0; e_min = 1'b0; e_sec = 1'b0;

    if (edit && !(mp || ip || il)) begin
      m_idle++;
      if (m_idle >= TMO) begin to = 1'b1; m_idle = 0; end
    end else begin
      m_idle = 0;
    end

    if (mp) nxt = (m_field + 1) % 4;
    else if (to) nxt = 0;

    if (edit && !mp) begin
      if (ip) begin
        str = 1'b1; m_armed = 1'b1; m_n = 0;
      end else if (m_armed && il) begin
        m_n++;
        if (m_n == DLY || (m_n > DLY && (m_n - DLY) % RATE == 0)) str = 1'b1;
      end else begin
        m_armed = 1'b0; m_n = 0;
      end
    end else begin
      m_armed = 1'b0; m_n = 0;
    end

    if (!edit && tk) e_sec = 1'b1;
    if (str) begin
      if (m_field == 1) e_hr = 1'b1;
      if (m_field == 2) e_min = 1'b1;
      if (m_field == 3) e_sec = 1'b1;
    end

    if (nxt == 0 || nxt != m_field) m_blink = 1'b1;
    else if (tk) m_blink = ~m_blink;
    m_field = nxt;
  endfunction

  task automatic chk_all(input string ph);
    chk({ph, ".RunEn"},  int'(bus.RunEn),  int'(m_field == 0));
    chk({ph, ".Field"},  int'(bus.Field),  m_field);
    chk({ph, ".Blink"},  int'(bus.Blink),  int'(m_blink));
    chk({ph, ".IncHr"},  int'(bus.IncHr),  int'(e_hr));
    chk({ph, ".IncMin"}, int'(bus.IncMin), int'(e_min));
    chk({ph, ".IncSec"}, int'(bus.IncSec), int'(e_sec));
  endtask

  // Called at posedge+1: drive inputs, advance model, check after the next edge.
  task automatic step(input bit mp, input bit ip, input bit il, input bit tk);
    bus.ModePulse = mp; bus.IncPulse = ip; bus.IncLevel = il; bus.Tick = tk;
    model(mp, ip, il, tk);
    @(posedge Clk);
    #1;
    chk_all("cyc");
    n_hr  += int'(bus.IncHr);
    n_min += int'(bus.IncMin);
    n_sec += int'(bus.IncSec);
    bus.ModePulse = 1'b0; bus.IncPulse = 1'b0; bus.IncLevel = 1'b0; bus.Tick = 1'b0;
  endtask

  task automatic clr_counts();
    n_hr = 0; n_min = 0; n_sec = 0;
  endtask

  initial begin
    bus.ModePulse = 1'b0; bus.IncPulse = 1'b0; bus.IncLevel = 1'b0; bus.Tick = 1'b0;
    lvl = 1'b0;
    clr_counts();
    model_reset();

    #2 Rst = 1'b0;
    #1 chk_all("reset");
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;

    // 1: ticks in run mode
    clr_counts();
    repeat (3) begin
      step(0, 0, 0, 1);
      chk("tick_sec", int'(bus.IncSec), 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    chk("run_sec_count", n_sec, 3);

    // 2: hours edit, single presses, ticks toggle blink only
    clr_counts();
    step(1, 0, 0, 0);
    chk("hr_field", int'(bus.Field), 1);
    chk("hr_runen", int'(bus.RunEn), 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("blink_toggle", int'(bus.Blink), 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    chk("blink_back", int'(bus.Blink), 1);
    step(0, 0, 0, 0);
    chk("hr_count", n_hr, 2);
    chk("hr_no_sec", n_sec, 0);

    // 3: minutes auto-repeat
    step(1, 0, 0, 0);
    clr_counts();
    step(0, 1, 1, 0);
    repeat (80) step(0, 0, 1, 0);
    repeat (30) step(0, 0, 0, 0);
    chk("rpt_min_count", n_min, 5);
    chk("rpt_no_hr", n_hr, 0);

    // 4: field sequence and exit without spurious IncSec
    clr_counts();
    step(1, 0, 0, 0);
    chk("seq_sec", int'(bus.Field), 3);
    step(1, 0, 0, 0);
    chk("seq_run", int'(bus.Field), 0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0, 0);
      chk("seq_cycle", int'(bus.Field), k % 4);
    end
    chk("exit_runen", int'(bus.RunEn), 1);
    step(0, 0, 0, 0);
    chk("exit_no_sec", n_sec, 0);
    step(0, 0, 0, 1);
    chk("exit_tick_sec", n_sec, 1);

    // 5: inactivity timeout, restarted by a level pulse at idle cycle 999
    step(1, 0, 0, 0);
    for (int i = 0; i < 998; i++) step(0, 0, 0, (i % 100) == 50);
    step(0, 0, 1, 0);
    repeat (999) step(0, 0, 0, 0);
    chk("tmo_still_edit", int'(bus.Field), 1);
    step(0, 0, 0, 0);
    chk("tmo_field", int'(bus.Field), 0);
    chk("tmo_blink", int'(bus.Blink), 1);
    chk("tmo_runen", int'(bus.RunEn), 1);

    // 6: mode beats increment; async reset mid-repeat
    step(1, 0, 0, 0);
    clr_counts();
    step(1, 1, 0, 0);
    chk("mode_wins_field", int'(bus.Field), 2);
    chk("mode_wins_nostrobe", n_hr + n_min, 0);
    step(0, 1, 1, 0);
    repeat (DLY) step(0, 0, 1, 0);
    chk("rpt_before_rst", int'(bus.IncMin), 1);
    #3 Rst = 1'b0;
    model_reset();
    #1 chk_all("async_rst");
    @(posedge Clk);
    #1 chk_all("held_rst");
    Rst = 1'b1;

    // random traffic against the model
    repeat (2000) begin
      if ($urandom_range(29) == 0) lvl = ~lvl;
      step($urandom_range(39) == 0, $urandom_range(19) == 0, lvl, $urandom_range(24) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequencing controller for the digital-clock time-keeping datapath.
- Takes single-cycle button pulses from the shaper stage (mode, increment), the raw increment-button level, and a 1 Hz tick.
- Drives one-cycle increment strobes to the hour, minute and seconds counters, and a field-select/blink pair to the display.
- Owns run/edit sequencing, auto-repeat of a held increment button, and an edit-mode inactivity timeout.

Parameters:
CNT_W, 16, width of internal delay/repeat/timeout counters
REPEAT_DELAY, 50, cycles IncLevel must stay high after an IncPulse before auto-repeat starts
REPEAT_RATE, 10, cycles between auto-repeat strobes once repeating
TIMEOUT, 1000, idle cycles in any edit state before forced return to run

Ports:
Clk  input  1  system clock, all state on rising edge
Rst  input  1  asynchronous reset, active-low
ModePulse  input  1  one-cycle pulse from button shaper, advances edit field
IncPulse  input  1  one-cycle pulse from button shaper, increments current field
IncLevel  input  1  raw (synchronised) increment button level, for auto-repeat
Tick  input  1  one-cycle 1 Hz timebase pulse
RunEn  output  1  high while clock is running (not editing)
IncHr  output  1  one-cycle hour-counter increment strobe
IncMin  output  1  one-cycle minute-counter increment strobe
IncSec  output  1  one-cycle seconds-counter increment strobe
Field  output  2  0=run, 1=hours, 2=minutes, 3=seconds being edited
Blink  output  1  display enable for edited field (1 = lit)

Behaviour:
- Reset (Rst low, async): state sRun, all counters 0, RunEn=1, IncHr=IncMin=IncSec=0, Field=0, Blink=1.
- All outputs are registered. Every strobe appears exactly one cycle after the causing input and lasts one cycle.
- States: sRun, sSetHr, sSetMin, sSetSec. Field equals the state encoding 0..3.
- ModePulse advances sRun->sSetHr->sSetMin->sSetSec->sRun. State updates on the edge where ModePulse is sampled high.
- sRun: RunEn=1, Blink=1. Each Tick gives IncSec one cycle later. IncPulse/IncLevel are ignored.
- Edit states: RunEn=0. Tick does not increment anything. Each Tick toggles Blink. Blink is forced to 1 on entry to any edit state.
- Edit increment: IncPulse in sSetHr/sSetMin/sSetSec gives one strobe on IncHr/IncMin/IncSec respectively.
- Auto-repeat: an accepted IncPulse clears the repeat counter.
  - While IncLevel stays high, the counter increments each cycle.
  - When the count reaches REPEAT_DELAY, one strobe is issued; thereafter one strobe every REPEAT_RATE cycles.
  - IncLevel low clears the counter and stops repeating immediately; no further strobes.
- Timeout: idle counter clears on any cycle with ModePulse, IncPulse or IncLevel high, and counts otherwise.
  - Reaching TIMEOUT in an edit state forces sRun; RunEn=1 the next cycle.
  - The idle counter is held at 0 in sRun.
- Simultaneous events:
  - ModePulse with IncPulse in the same cycle: mode wins, no strobe, repeat counter cleared.
  - Timeout and ModePulse in the same cycle cannot occur, because ModePulse clears idle.
  - A mode change cancels any auto-repeat in progress.
- Leaving sSetSec to sRun issues no IncSec. The first IncSec after that follows the next Tick.
- At most one of IncHr/IncMin/IncSec is high in any cycle.
- Counters saturate; they never wrap.
- Reset asserted mid-edit or mid-repeat returns everything to reset values immediately, with no strobe generated.

Test Plan:
1. Reset released, Tick pulsed 3 times -> IncSec high 3 single cycles, each one cycle after Tick; RunEn=1, Field=0 throughout.
2. ModePulse x1 then IncPulse x2 (IncLevel low) -> Field=1, RunEn=0, exactly 2 IncHr strobes; Ticks in between give no IncSec and toggle Blink.
3. In sSetMin, IncPulse then IncLevel held 80 cycles (delay 50, rate 10) -> IncMin strobes: 1 initial + at count 50, 60, 70, 80 = 5; release -> no more.
4. ModePulse x3 then x1 -> Field 1,2,3, then 0 with RunEn=1 and no spurious IncSec on exit.
5. Enter sSetHr, idle 1000 cycles -> at TIMEOUT state returns to sRun, Field=0, Blink=1; IncLevel pulse at cycle 999 restarts the count.
6. ModePulse and IncPulse same cycle in sSetHr -> Field=2, no IncHr/IncMin; Rst low during auto-repeat -> outputs at reset values asynchronously.
